// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into an APB SETUP/ACCESS transfer
// and returns a one-cycle response pulse carrying read data and an error flag.
module apb_master #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              psel_o,
   output logic              penable_o,
   output logic              pwrite_o,
   output logic [ADDR_W-1:0] paddr_o,
   output logic [DATA_W-1:0] pwdata_o,
   input  logic [DATA_W-1:0] prdata_i,
   input  logic              pready_i,
   input  logic              pslverr_i
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                req_ready_q, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid_i && req_ready_q) begin
               state_d   = SETUP;
               cnt_d     = '0;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = req_write_i;
               paddr_d   = req_addr_i;
               pwdata_d  = req_write_i ? req_wdata_i : '0;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (pready_i) begin
               state_d     = IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = pslverr_i;
               rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
            end else if (cnt_q == CNT_LAST) begin
               // Slave never became ready: abort with an error response
               state_d     = IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase

      req_ready_d = (state_d == IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign psel_o      = psel_q;
   assign penable_o   = penable_q;
   assign pwrite_o    = pwrite_q;
   assign paddr_o     = paddr_q;
   assign pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level model checked every cycle, directed
// scenarios with literal expectations, then a randomized traffic phase.
module tb_apb_master;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 8;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata = '0;
   logic          pready = 1'b0;
   logic          pslverr = 1'b0;

   always #5 clk = ~clk;

   apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
      .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: a transfer is "busy" from acceptance until its response
   logic [DW-1:0] mem [32];
   bit            m_busy = 1'b0;
   int            m_age = 0;
   int            m_acc = 0;
   bit            m_wr = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic          e_psel = 0, e_pen = 0, e_pwrite = 0, e_rv = 0, e_err = 0, e_ready = 0;
   logic [AW-1:0] e_paddr = '0;
   logic [DW-1:0] e_pwdata = '0, e_rdata = '0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_busy = 1'b0;
         e_psel = 0; e_pen = 0; e_pwrite = 0; e_paddr = '0; e_pwdata = '0;
         e_rv = 0; e_rdata = '0; e_err = 0; e_ready = 0;
      end else begin
         e_rv = 1'b0;
         if (!m_busy) begin
            if (req_valid && e_ready) begin
               m_busy = 1'b1; m_age = 1;
               m_wr = req_write; m_addr = req_addr;
               m_wdata = req_write ? req_wdata : '0;
               e_psel = 1; e_pen = 0; e_pwrite = m_wr; e_paddr = m_addr; e_pwdata = m_wdata;
            end
         end else if (m_age == 1) begin
            m_age = 2; m_acc = 0; e_pen = 1;
         end else begin
            m_acc++;
            if (pready || m_acc == int'(TO)) begin
               m_busy = 1'b0; e_psel = 0; e_pen = 0; e_rv = 1;
               e_err   = pready ? pslverr : 1'b1;
               e_rdata = (pready && !pslverr && !m_wr) ? prdata : '0;
               if (pready && !pslverr && m_wr) mem[m_addr] = m_wdata;
            end
         end
         e_ready = !m_busy;
      end
   end

   // Slave stimulus: directed wait/error knobs or random; noise outside ACCESS
   bit rnd_mode = 1'b0;
   bit stall = 1'b0;
   bit err_knob = 1'b0;
   int wait_left = 0;

   always @(negedge clk) begin
      if (m_busy && m_age == 2) begin
         if (rnd_mode) begin
            pready  = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            pslverr = ($urandom_range(0, 4) == 0);
         end else begin
            pready  = (wait_left == 0);
            if (wait_left > 0) wait_left--;
            pslverr = err_knob;
         end
         prdata = m_wr ? DW'($urandom) : mem[m_addr];
      end else begin
         pready  = 1'($urandom);
         pslverr = 1'($urandom);
         prdata  = DW'($urandom);
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", 32'(req_ready), 32'(e_ready));
         chk("psel",      32'(psel),      32'(e_psel));
         chk("penable",   32'(penable),   32'(e_pen));
         chk("pwrite",    32'(pwrite),    32'(e_pwrite));
         chk("paddr",     32'(paddr),     32'(e_paddr));
         chk("pwdata",    32'(pwdata),    32'(e_pwdata));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
         chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
         chk("rsp_err",   32'(rsp_err),   32'(e_err));
      end
   end

   // Issue one command and follow it to its response; lat counts cycles after acceptance
   task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int waits, input bit err,
                          output int lat, output int nacc, output logic [DW-1:0] rd,
                          output logic e, output logic [DW-1:0] acc_wdata);
      int guard = 0;
      bit done = 1'b0;
      while (!req_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      wait_left = waits; err_knob = err;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0; req_write = ~wr; req_addr = AW'($urandom); req_wdata = DW'($urandom);
      lat = 1; nacc = 0; rd = '0; e = 1'b0; acc_wdata = '0;
      for (int i = 0; i < 100; i++) begin
         if (psel && penable) begin
            nacc++;
            acc_wdata = pwdata;
         end
         if (rsp_valid) begin
            rd = rsp_rdata; e = rsp_err; done = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         lat = -1;
         chk("rsp_timeout", 32'(0), 32'(1));
      end
   endtask

   int lat, nacc, c1, c2;
   logic [DW-1:0] rd, aw;
   logic e;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_psel", 32'(psel), 32'(0));
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready), 32'(1));

      // Zero-wait write
      run_txn(1'b1, 5'h04, 8'hA5, 0, 1'b0, lat, nacc, rd, e, aw);
      chk("wr_lat", 32'(lat), 32'(3));
      chk("wr_nacc", 32'(nacc), 32'(1));
      chk("wr_pwdata", 32'(aw), 32'(8'hA5));
      chk("wr_rdata", 32'(rd), 32'(0));
      chk("wr_err", 32'(e), 32'(0));
      chk("wr_ready_in_rsp", 32'(req_ready), 32'(1));

      // Read after write
      run_txn(1'b1, 5'h08, 8'h3C, 0, 1'b0, lat, nacc, rd, e, aw);
      run_txn(1'b0, 5'h08, 8'hFF, 0, 1'b0, lat, nacc, rd, e, aw);
      chk("raw_rdata", 32'(rd), 32'(8'h3C));
      chk("raw_err", 32'(e), 32'(0));
      chk("raw_pwdata", 32'(aw), 32'(0));

      // Wait states
      run_txn(1'b1, 5'h03, 8'h5A, 0, 1'b0, lat, nacc, rd, e, aw);
      run_txn(1'b0, 5'h03, 8'h00, 3, 1'b0, lat, nacc, rd, e, aw);
      chk("ws_lat", 32'(lat), 32'(6));
      chk("ws_nacc", 32'(nacc), 32'(4));
      chk("ws_rdata", 32'(rd), 32'(8'h5A));

      // Slave error then clean read
      run_txn(1'b1, 5'h0C, 8'h99, 0, 1'b1, lat, nacc, rd, e, aw);
      chk("serr_err", 32'(e), 32'(1));
      chk("serr_rdata", 32'(rd), 32'(0));
      run_txn(1'b0, 5'h08, 8'h00, 0, 1'b0, lat, nacc, rd, e, aw);
      chk("serr_next_err", 32'(e), 32'(0));
      chk("serr_next_rdata", 32'(rd), 32'(8'h3C));

      // Timeout
      run_txn(1'b0, 5'h08, 8'h00, -1, 1'b0, lat, nacc, rd, e, aw);
      chk("to_lat", 32'(lat), 32'(TO + 2));
      chk("to_nacc", 32'(nacc), 32'(TO));
      chk("to_err", 32'(e), 32'(1));
      chk("to_rdata", 32'(rd), 32'(0));
      chk("to_psel", 32'(psel), 32'(0));
      chk("to_ready", 32'(req_ready), 32'(1));

      // Reset during a waited read
      wait_left = -1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h04;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_psel", 32'(psel), 32'(0));
      chk("mrst_penable", 32'(penable), 32'(0));
      chk("mrst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("mrst_paddr", 32'(paddr), 32'(0));
      chk("mrst_rdata", 32'(rsp_rdata), 32'(0));
      chk("mrst_err", 32'(rsp_err), 32'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_ready", 32'(req_ready), 32'(1));
      run_txn(1'b1, 5'h10, 8'h77, 0, 1'b0, lat, nacc, rd, e, aw);
      chk("mrst_wr_lat", 32'(lat), 32'(3));
      chk("mrst_wr_err", 32'(e), 32'(0));

      // Back-to-back: next request accepted in the rsp_valid cycle
      c1 = cyc;
      run_txn(1'b0, 5'h10, 8'h00, 0, 1'b0, lat, nacc, rd, e, aw);
      c2 = cyc;
      chk("b2b_rdata", 32'(rd), 32'(8'h77));
      chk("b2b_period", 32'(c2 - c1), 32'(3));

      // Randomized traffic with stall windows and occasional resets
      rnd_mode = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         stall     = ((i % 256) >= 200);
         rst       = ($urandom_range(0, 499) == 0);
         req_valid = 1'($urandom);
         req_write = 1'($urandom);
         req_addr  = AW'($urandom);
         req_wdata = DW'($urandom);
         @(negedge clk);
      end
      rst = 1'b0; req_valid = 1'b0;
      repeat (TO + 4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (initiator) that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers.
- Returns a one-cycle response pulse carrying read data and an error flag.
- Sits between a control FSM or testbench agent and the team's APB register slaves (cntrl, reg1..reg4 at word addresses 0x00..0x10).
- Adds wait-state support via pready, error reporting via pslverr, and an ACCESS-phase timeout.

Parameters:
- ADDR_W, 5, width of req_addr and paddr.
- DATA_W, 8, width of the data buses.
- TIMEOUT, 16, maximum ACCESS cycles before abort. Legal range is >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  command request.
- req_ready  out  1  block can accept a command.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  transfer address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for aborts.
- rsp_err  out  1  slave error or timeout; qualified by rsp_valid.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready. Tie to 1 for zero-wait slaves.
- pslverr  in  1  APB slave error. Tie to 0 if unsupported.

Behaviour:
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- Reset (rst=1 at a clk edge), from any state including mid-transfer:
  - state goes to IDLE;
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err all go to 0;
  - timeout counter clears;
  - an in-flight transfer is dropped with no response.
- req_ready = 1 only in IDLE. It is 0 during reset.
- IDLE: on an edge with req_valid & req_ready:
  - latch req_write to pwrite and req_addr to paddr;
  - pwdata = req_wdata if write, else 0;
  - go to SETUP.
- SETUP (exactly one cycle): psel=1, penable=0, then go to ACCESS.
- ACCESS: psel=1, penable=1. paddr, pwrite and pwdata are held stable. pready and prdata are sampled at each edge.
  - pready=1: go to IDLE and assert rsp_valid for the next cycle.
    - rsp_err = pslverr.
    - rsp_rdata = prdata for a read with pslverr=0; otherwise 0.
    - psel and penable drop to 0 in the same cycle.
  - pready=0: increment the wait counter.
    - If the counter already equals TIMEOUT-1, abort: go to IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0, psel and penable drop to 0.
    - The ACCESS phase therefore lasts at most TIMEOUT cycles.
- The wait counter is $clog2(TIMEOUT+1) bits wide. It clears on entry to SETUP.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata and rsp_err are held until the next response.
- Latency and throughput:
  - request accepted at edge T;
  - SETUP during cycle T+1;
  - ACCESS during T+2 (+ wait states);
  - rsp_valid during T+3 (+ wait states).
- In the rsp_valid cycle req_ready=1, so a new request can be accepted in that cycle. Back-to-back throughput is one transfer per 3 cycles.
- paddr, pwrite and pwdata hold their last values while IDLE. psel=0 whenever not in SETUP/ACCESS.
- req_* inputs are ignored outside IDLE. Changes to req_* after acceptance do not affect the transfer.
- Against the team's existing slave, which has no pready/pslverr: tie pready=1 and pslverr=0. That slave updates prdata from paddr on every non-write edge, so prdata is valid by the ACCESS sample.

Test Plan:
- Write, zero-wait: req write addr=0x04 data=0xA5, pready=1.
  - Expect psel=1/penable=0 for one cycle, then psel=1/penable=1 for one cycle with paddr=0x04, pwrite=1, pwdata=0xA5.
  - Expect rsp_valid at T+3 with rsp_err=0 and rsp_rdata=0.
- Read-after-write against the register slave model: write 0x3C to 0x08, then read 0x08.
  - Expect rsp_rdata=0x3C, rsp_err=0.
  - Expect pwdata=0 during the read.
- Wait states: read with pready low for 3 ACCESS cycles, prdata=0x5A on the ready cycle.
  - Expect ACCESS to last 4 cycles, rsp_valid at T+6, rsp_rdata=0x5A.
- Slave error: write with pready=1, pslverr=1.
  - Expect rsp_err=1 and rsp_rdata=0.
  - A following read with pslverr=0 shows rsp_err=0.
- Timeout: TIMEOUT=16, pready held 0.
  - Expect exactly 16 ACCESS cycles, then psel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, and req_ready=1 the same cycle.
- Reset mid-ACCESS: assert rst during a waited read.
  - Next cycle: all outputs 0 and no rsp_valid.
  - After rst deasserts: req_ready=1, and a new write to 0x10 completes normally.
  - Also check back-to-back requests are accepted in the rsp_valid cycle.
